sobel_dma_ctrl: RTL and testbench

Register-programmed controller that sequences the Sobel accelerator datapath in the user domain. Software programs source address, destination address and word count through an OBI-style subordinate port decoded at the `SobelAccel` window (`UserBaseAddr`, 4 KiB). The block then streams words from memory over the user-domain manager port into the accelerator. It writes each result word back to memory, one word at a time, and raises `irq_o` on completion or bus error.

---
 rtl/sobel_dma_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_sobel_dma_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_dma_ctrl.sv
// sobel_dma_ctrl: register-programmed sequencer that streams words from memory
// through the Sobel accelerator and writes each result back, one word at a time.
module sobel_dma_ctrl #(
    parameter int LenWidth = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sbr_req_i,
    input  logic        sbr_we_i,
    input  logic [11:0] sbr_addr_i,
    input  logic [31:0] sbr_wdata_i,
    input  logic [3:0]  sbr_be_i,
    output logic        sbr_gnt_o,
    output logic        sbr_rvalid_o,
    output logic [31:0] sbr_rdata_o,
    output logic        sbr_err_o,
    output logic        mgr_req_o,
    output logic        mgr_we_o,
    output logic [31:0] mgr_addr_o,
    output logic [3:0]  mgr_be_o,
    output logic [31:0] mgr_wdata_o,
    input  logic        mgr_gnt_i,
    input  logic        mgr_rvalid_i,
    input  logic        mgr_err_i,
    input  logic [31:0] mgr_rdata_i,
    output logic        acc_in_valid_o,
    input  logic        acc_in_ready_i,
    output logic [31:0] acc_in_data_o,
    input  logic        acc_out_valid_i,
    output logic        acc_out_ready_o,
    input  logic [31:0] acc_out_data_i,
    output logic        irq_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_REQ = 3'd1;
    localparam logic [2:0] ST_RD_RSP = 3'd2;
    localparam logic [2:0] ST_PUSH   = 3'd3;
    localparam logic [2:0] ST_POP    = 3'd4;
    localparam logic [2:0] ST_WR_REQ = 3'd5;
    localparam logic [2:0] ST_WR_RSP = 3'd6;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_SRC    = 12'h008;
    localparam logic [11:0] OFF_DST    = 12'h00C;
    localparam logic [11:0] OFF_LEN    = 12'h010;

    logic [2:0]          state_q, state_d;
    logic [31:0]         src_q, src_d;
    logic [31:0]         dst_q, dst_d;
    logic [LenWidth-1:0] len_q, len_d;
    logic [LenWidth-1:0] idx_q, idx_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         res_q, res_d;
    logic                irq_en_q, irq_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                rvalid_q, rvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rerr_q, rerr_d;

    logic                busy;
    logic                start_acc;
    logic [31:0]         word_off;
    logic                unused_be;

    // Byte enables are not used: the register file only supports full-word access.
    assign unused_be = ^sbr_be_i;

    assign busy     = (state_q != ST_IDLE);
    assign word_off = 32'(idx_q) << 2;

    // Register state, cleared asynchronously so a reset aborts a transfer at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            res_q    <= '0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            res_q    <= res_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rerr_q   <= rerr_d;
        end
    end

    // Register writes followed by the FSM; hardware sets of DONE/ERR come last so they beat a W1C.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        idx_d     = idx_q;
        data_d    = data_q;
        res_d     = res_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        err_d     = err_q;
        start_acc = 1'b0;

        if (sbr_req_i && sbr_we_i) begin
            case (sbr_addr_i)
                OFF_CTRL: begin
                    irq_en_d  = sbr_wdata_i[1];
                    start_acc = sbr_wdata_i[0] && !busy;
                end
                OFF_STATUS: begin
                    if (sbr_wdata_i[1]) done_d = 1'b0;
                    if (sbr_wdata_i[2]) err_d = 1'b0;
                end
                OFF_SRC: if (!busy) src_d = {sbr_wdata_i[31:2], 2'b00};
                OFF_DST: if (!busy) dst_d = {sbr_wdata_i[31:2], 2'b00};
                OFF_LEN: if (!busy) len_d = sbr_wdata_i[LenWidth-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    idx_d  = '0;
                    if (len_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: if (mgr_gnt_i) state_d = ST_RD_RSP;
            ST_RD_RSP: begin
                if (mgr_rvalid_i) begin
                    data_d  = mgr_rdata_i;
                    state_d = mgr_err_i ? ST_ERR : ST_PUSH;
                end
            end
            ST_PUSH: if (acc_in_ready_i) state_d = ST_POP;
            ST_POP: begin
                if (acc_out_valid_i) begin
                    res_d   = acc_out_data_i;
                    state_d = ST_WR_REQ;
                end
            end
            ST_WR_REQ: if (mgr_gnt_i) state_d = ST_WR_RSP;
            ST_WR_RSP: begin
                if (mgr_rvalid_i) begin
                    if (mgr_err_i) begin
                        state_d = ST_ERR;
                    end else if (idx_q == len_q - LenWidth'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + LenWidth'(1);
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_ERR: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Subordinate response: registered one cycle after the combinational grant.
    always_comb begin
        rvalid_d = sbr_req_i;
        rdata_d  = '0;
        rerr_d   = 1'b0;
        if (sbr_req_i) begin
            case (sbr_addr_i)
                OFF_CTRL:   if (!sbr_we_i) rdata_d = {30'd0, irq_en_q, 1'b0};
                OFF_STATUS: if (!sbr_we_i) rdata_d = {29'd0, err_q, done_q, busy};
                OFF_SRC:    if (!sbr_we_i) rdata_d = src_q;
                OFF_DST:    if (!sbr_we_i) rdata_d = dst_q;
                OFF_LEN:    if (!sbr_we_i) rdata_d = 32'(len_q);
                default:    rerr_d = 1'b1;
            endcase
        end
    end

    // Manager request fields come straight from the FSM state so they hold until granted.
    always_comb begin
        mgr_req_o   = 1'b0;
        mgr_we_o    = 1'b0;
        mgr_be_o    = 4'h0;
        mgr_addr_o  = '0;
        mgr_wdata_o = '0;
        if (state_q == ST_RD_REQ) begin
            mgr_req_o  = 1'b1;
            mgr_addr_o = src_q + word_off;
        end else if (state_q == ST_WR_REQ) begin
            mgr_req_o   = 1'b1;
            mgr_we_o    = 1'b1;
            mgr_be_o    = 4'hF;
            mgr_addr_o  = dst_q + word_off;
            mgr_wdata_o = res_q;
        end
    end

    assign sbr_gnt_o       = sbr_req_i;
    assign sbr_rvalid_o    = rvalid_q;
    assign sbr_rdata_o     = rdata_q;
    assign sbr_err_o       = rerr_q;
    assign acc_in_valid_o  = (state_q == ST_PUSH);
    assign acc_in_data_o   = data_q;
    assign acc_out_ready_o = (state_q == ST_POP);
    assign irq_o           = irq_en_q & (done_q | err_q);

endmodule

// File: tb/tb_sobel_dma_ctrl.sv
// tb_sobel_dma_ctrl: directed bench with a memory model and an identity accelerator model.
module tb_sobel_dma_ctrl;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sbr_req_i = 1'b0;
    logic        sbr_we_i = 1'b0;
    logic [11:0] sbr_addr_i = '0;
    logic [31:0] sbr_wdata_i = '0;
    logic [3:0]  sbr_be_i = 4'hF;
    logic        sbr_gnt_o;
    logic        sbr_rvalid_o;
    logic [31:0] sbr_rdata_o;
    logic        sbr_err_o;
    logic        mgr_req_o;
    logic        mgr_we_o;
    logic [31:0] mgr_addr_o;
    logic [3:0]  mgr_be_o;
    logic [31:0] mgr_wdata_o;
    logic        mgr_gnt_i = 1'b0;
    logic        mgr_rvalid_i = 1'b0;
    logic        mgr_err_i = 1'b0;
    logic [31:0] mgr_rdata_i = '0;
    logic        acc_in_valid_o;
    logic        acc_in_ready_i = 1'b0;
    logic [31:0] acc_in_data_o;
    logic        acc_out_valid_i = 1'b0;
    logic        acc_out_ready_o;
    logic [31:0] acc_out_data_i = '0;
    logic        irq_o;

    int nChecks = 0;
    int nFail = 0;
    int reqCount = 0;
    int savedReq;

    logic [31:0] mem [0:1023];
    logic [31:0] logAddr [$];
    logic [31:0] logData [$];
    logic [3:0]  logBe [$];
    logic [31:0] expData [0:7];
    logic [31:0] errAddr = 32'hFFFF_FFFF;
    logic        randStall = 1'b0;

    sobel_dma_ctrl #(.LenWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .sbr_req_i(sbr_req_i), .sbr_we_i(sbr_we_i), .sbr_addr_i(sbr_addr_i),
        .sbr_wdata_i(sbr_wdata_i), .sbr_be_i(sbr_be_i), .sbr_gnt_o(sbr_gnt_o),
        .sbr_rvalid_o(sbr_rvalid_o), .sbr_rdata_o(sbr_rdata_o), .sbr_err_o(sbr_err_o),
        .mgr_req_o(mgr_req_o), .mgr_we_o(mgr_we_o), .mgr_addr_o(mgr_addr_o),
        .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o), .mgr_gnt_i(mgr_gnt_i),
        .mgr_rvalid_i(mgr_rvalid_i), .mgr_err_i(mgr_err_i), .mgr_rdata_i(mgr_rdata_i),
        .acc_in_valid_o(acc_in_valid_o), .acc_in_ready_i(acc_in_ready_i),
        .acc_in_data_o(acc_in_data_o), .acc_out_valid_i(acc_out_valid_i),
        .acc_out_ready_o(acc_out_ready_o), .acc_out_data_i(acc_out_data_i),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        sbr_req_i = 1'b1; sbr_we_i = 1'b1; sbr_addr_i = a; sbr_wdata_i = d;
        @(negedge clk);
        sbr_req_i = 1'b0; sbr_we_i = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [11:0] a,
                             input logic [31:0] expD, input logic expE);
        @(negedge clk);
        sbr_req_i = 1'b1; sbr_we_i = 1'b0; sbr_addr_i = a;
        #1 checkOutput({tag, "_gnt"}, {31'd0, sbr_gnt_o}, 32'd1);
        @(negedge clk);
        sbr_req_i = 1'b0;
        checkOutput({tag, "_rvalid"}, {31'd0, sbr_rvalid_o}, 32'd1);
        checkOutput({tag, "_data"}, sbr_rdata_o, expD);
        checkOutput({tag, "_err"}, {31'd0, sbr_err_o}, {31'd0, expE});
    endtask

    task automatic waitIrq(input string tag, input int budget);
        int n = 0;
        while (!irq_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'd0, irq_o}, 32'd1);
    endtask

    task automatic checkWrites(input string tag, input logic [31:0] dstBase, input int n);
        checkOutput({tag, "_count"}, 32'(logAddr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_addr"}, (i < logAddr.size()) ? logAddr[i] : 32'hDEAD_BEEF,
                        dstBase + 32'(4 * i));
            checkOutput({tag, "_data"}, (i < logData.size()) ? logData[i] : 32'hDEAD_BEEF,
                        expData[i]);
            checkOutput({tag, "_be"}, (i < logBe.size()) ? 32'(logBe[i]) : 32'hDEAD_BEEF, 32'hF);
        end
    endtask

    task automatic clearLog();
        logAddr.delete(); logData.delete(); logBe.delete();
    endtask

    // Memory model: grants after an optional stall, responds the cycle after the grant.
    logic        gntPend = 1'b0;
    logic        holdValid = 1'b0;
    int          stallCnt = 0;
    logic [31:0] holdAddr, holdWdata, respData;
    logic        holdWe, respErr;

    always @(negedge clk) begin
        if (!rst_ni) begin
            mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b0; mgr_err_i = 1'b0;
            gntPend = 1'b0; holdValid = 1'b0; stallCnt = 0;
        end else begin
            mgr_rvalid_i = 1'b0;
            mgr_err_i    = 1'b0;
            if (gntPend) begin
                mgr_gnt_i    = 1'b0;
                mgr_rvalid_i = 1'b1;
                mgr_rdata_i  = respData;
                mgr_err_i    = respErr;
                gntPend      = 1'b0;
            end else if (mgr_req_o) begin
                reqCount++;
                if (holdValid) begin
                    checkOutput("hold_addr", mgr_addr_o, holdAddr);
                    checkOutput("hold_we", {31'd0, mgr_we_o}, {31'd0, holdWe});
                    checkOutput("hold_wdata", mgr_wdata_o, holdWdata);
                end
                if (stallCnt > 0) begin
                    stallCnt--;
                    mgr_gnt_i = 1'b0;
                    holdValid = 1'b1;
                    holdAddr  = mgr_addr_o;
                    holdWe    = mgr_we_o;
                    holdWdata = mgr_wdata_o;
                end else begin
                    mgr_gnt_i = 1'b1;
                    gntPend   = 1'b1;
                    holdValid = 1'b0;
                    if (mgr_we_o) begin
                        mem[mgr_addr_o[11:2]] = mgr_wdata_o;
                        logAddr.push_back(mgr_addr_o);
                        logData.push_back(mgr_wdata_o);
                        logBe.push_back(mgr_be_o);
                        respData = 32'd0;
                        respErr  = 1'b0;
                    end else begin
                        respData = mem[mgr_addr_o[11:2]];
                        respErr  = (mgr_addr_o == errAddr);
                    end
                    stallCnt = randStall ? int'($urandom_range(0, 5)) : 0;
                end
            end else begin
                mgr_gnt_i = 1'b0;
            end
        end
    end

    // Accelerator model: identity function, one word in flight, two-cycle latency.
    logic        haveWord = 1'b0;
    logic        popNext = 1'b0;
    int          accDelay = 0;
    logic [31:0] accWord;

    always @(negedge clk) begin
        if (!rst_ni) begin
            haveWord = 1'b0; popNext = 1'b0; acc_out_valid_i = 1'b0; acc_in_ready_i = 1'b0;
        end else begin
            if (popNext) begin
                acc_out_valid_i = 1'b0;
                popNext = 1'b0;
            end
            if (haveWord) begin
                if (accDelay > 0) begin
                    accDelay--;
                end else begin
                    acc_out_valid_i = 1'b1;
                    acc_out_data_i  = accWord;
                    haveWord = 1'b0;
                end
            end
            acc_in_ready_i = randStall ? ($urandom_range(0, 2) == 0) : 1'b1;
            if (acc_in_valid_o && acc_in_ready_i && !haveWord && !acc_out_valid_i) begin
                haveWord = 1'b1;
                accWord  = acc_in_data_o;
                accDelay = 1;
            end else if (acc_in_valid_o) begin
                acc_in_ready_i = 1'b0;
            end
            if (acc_out_valid_i && acc_out_ready_o) popNext = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[10'h040] = 32'hA; mem[10'h041] = 32'hB; mem[10'h042] = 32'hC;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_mgr_req", {31'd0, mgr_req_o}, 32'd0);
        checkOutput("rst_mgr_be", {28'd0, mgr_be_o}, 32'd0);
        checkOutput("rst_acc_in_valid", {31'd0, acc_in_valid_o}, 32'd0);
        checkOutput("rst_acc_out_ready", {31'd0, acc_out_ready_o}, 32'd0);
        checkOutput("rst_sbr_rvalid", {31'd0, sbr_rvalid_o}, 32'd0);
        checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
        rst_ni = 1'b1;
        readCheck("rst_status", 12'h004, 32'h0, 1'b0);
        readCheck("rst_ctrl", 12'h000, 32'h0, 1'b0);

        // Three-word identity transfer with interrupt enabled
        applyStimulus(12'h008, 32'h2000_0100);
        applyStimulus(12'h00C, 32'h2000_0200);
        applyStimulus(12'h010, 32'd3);
        applyStimulus(12'h000, 32'h2);
        readCheck("t1_ctrl", 12'h000, 32'h2, 1'b0);
        applyStimulus(12'h000, 32'h3);
        readCheck("t1_busy", 12'h004, 32'h1, 1'b0);
        waitIrq("t1_irq", 300);
        expData[0] = 32'hA; expData[1] = 32'hB; expData[2] = 32'hC;
        checkWrites("t1_wr", 32'h2000_0200, 3);
        readCheck("t1_status", 12'h004, 32'h2, 1'b0);
        readCheck("t1_src", 12'h008, 32'h2000_0100, 1'b0);
        applyStimulus(12'h004, 32'h2);
        checkOutput("t1_irq_clr", {31'd0, irq_o}, 32'd0);
        readCheck("t1_status_clr", 12'h004, 32'h0, 1'b0);

        // Zero-length start completes without bus traffic
        savedReq = reqCount;
        applyStimulus(12'h010, 32'd0);
        applyStimulus(12'h000, 32'h3);
        readCheck("len0_status", 12'h004, 32'h2, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("len0_noreq", 32'(reqCount), 32'(savedReq));
        applyStimulus(12'h004, 32'h2);

        // Read error on the second word
        clearLog();
        errAddr = 32'h2000_0104;
        applyStimulus(12'h010, 32'd3);
        applyStimulus(12'h000, 32'h3);
        waitIrq("err_irq", 300);
        readCheck("err_status", 12'h004, 32'h4, 1'b0);
        expData[0] = 32'hA;
        checkWrites("err_wr", 32'h2000_0200, 1);
        applyStimulus(12'h004, 32'h4);
        readCheck("err_status_clr", 12'h004, 32'h0, 1'b0);
        checkOutput("err_irq_clr", {31'd0, irq_o}, 32'd0);
        errAddr = 32'hFFFF_FFFF;

        // Eight words with random bus and accelerator stalls; writes while busy are dropped
        clearLog();
        for (int i = 0; i < 8; i++) begin
            mem[10'h040 + 10'(i)] = 32'hC0DE_0000 + 32'(i * 32'h111);
            expData[i] = 32'hC0DE_0000 + 32'(i * 32'h111);
        end
        randStall = 1'b1;
        applyStimulus(12'h00C, 32'h2000_0300);
        applyStimulus(12'h010, 32'd8);
        applyStimulus(12'h000, 32'h3);
        applyStimulus(12'h008, 32'h0000_0123);
        applyStimulus(12'h010, 32'd5);
        readCheck("busy_src", 12'h008, 32'h2000_0100, 1'b0);
        readCheck("busy_len", 12'h010, 32'd8, 1'b0);
        readCheck("busy_status", 12'h004, 32'h1, 1'b0);
        waitIrq("stall_irq", 3000);
        checkWrites("stall_wr", 32'h2000_0300, 8);
        readCheck("stall_status", 12'h004, 32'h2, 1'b0);
        randStall = 1'b0;
        applyStimulus(12'h004, 32'h2);

        // Idle register writes, LEN width, unmapped offset
        applyStimulus(12'h008, 32'h0000_0123);
        readCheck("idle_src", 12'h008, 32'h0000_0120, 1'b0);
        applyStimulus(12'h010, 32'hFFFF_FFFF);
        readCheck("len_width", 12'h010, 32'h0000_FFFF, 1'b0);
        readCheck("bad_off", 12'h020, 32'h0, 1'b1);

        // Reset pulsed while a write request is pending
        applyStimulus(12'h008, 32'h2000_0100);
        applyStimulus(12'h00C, 32'h2000_0200);
        applyStimulus(12'h010, 32'd2);
        applyStimulus(12'h000, 32'h3);
        begin
            int n = 0;
            while (!(mgr_req_o && mgr_we_o) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("rstmid_in_wrreq", {31'd0, mgr_req_o & mgr_we_o}, 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("rstmid_req", {31'd0, mgr_req_o}, 32'd0);
        checkOutput("rstmid_we", {31'd0, mgr_we_o}, 32'd0);
        checkOutput("rstmid_be", {28'd0, mgr_be_o}, 32'd0);
        checkOutput("rstmid_addr", mgr_addr_o, 32'd0);
        checkOutput("rstmid_wdata", mgr_wdata_o, 32'd0);
        checkOutput("rstmid_irq", {31'd0, irq_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        savedReq = reqCount;
        repeat (10) @(negedge clk);
        checkOutput("rstmid_noreq", 32'(reqCount), 32'(savedReq));
        readCheck("rstmid_status", 12'h004, 32'h0, 1'b0);
        readCheck("rstmid_len", 12'h010, 32'h0, 1'b0);
        clearLog();
        applyStimulus(12'h008, 32'h2000_0100);
        applyStimulus(12'h00C, 32'h2000_0400);
        applyStimulus(12'h010, 32'd1);
        applyStimulus(12'h000, 32'h3);
        waitIrq("rstmid_rerun_irq", 300);
        expData[0] = 32'hC0DE_0000;
        checkWrites("rstmid_rerun_wr", 32'h2000_0400, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
